timer_dev: RTL and testbench
============================

# timer_dev

Memory-mapped countdown timer device on the processor's peripheral bus, downstream of the CPU's PrA/PrWE/PrWD/PrRD port through the system bridge. Its interrupt output drives one bit of the CPU's HWInt vector. It provides three word registers (CTRL, PRESET, COUNT) and a four-state counting FSM with one-shot and auto-reload modes.

## Interface
- No parameters; base address decode is done by the bridge.
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low; clears all state
- addr  input  2  word offset within device (PrA[3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=unused
- we  input  1  write strobe for this device, already qualified by bridge decode
- wd  input  32  write data (PrWD)
- rd  output  32  read data, combinational from addr
- irq  output  1  interrupt request to HWInt

## Operation
- CTRL: bit0 EN, bits[2:1] MODE, bit3 IM (interrupt mask), bits[31:4] read 0 and ignore writes.
  - MODE 0: one-shot.
  - MODE 1: auto-reload.
  - MODE 2 and 3: behave as MODE 0.
- PRESET: full 32-bit read/write reload value.
- COUNT: read-only; writes ignored.
- Offset 3 reads 0; writes to it are ignored.
- irq = IM & irq_flag.
- FSM states:
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT: if !EN, go to IDLE and hold COUNT. Else if COUNT > 1, COUNT <= COUNT-1. Else COUNT <= 0, irq_flag <= 1, go to INT.
  - INT, MODE 0: EN <= 0; go to IDLE; irq_flag stays set.
  - INT, MODE 1: irq_flag <= 0; go to LOAD, giving a one-cycle pulse.
- irq_flag clears on any bus write to CTRL or PRESET.
- A write to PRESET during CNT does not affect COUNT until the next LOAD.
- FSM decisions use the register values before the edge. A write's effect on EN is seen one cycle later.
- Simultaneous events:
  - Bus write to CTRL in the same cycle as the INT MODE 0 EN clear: the written CTRL value wins.
  - irq_flag set and write-clear on the same edge: set wins.
  - Clearing EN in any state: the FSM reaches IDLE at the next edge. This includes LOAD, which goes to IDLE and skips CNT. COUNT retains its value.
- COUNT never wraps: CNT saturates at 0, and PRESET=0 behaves like PRESET=1.

## Timing
- Reset (asynchronous, while low):
  - CTRL, PRESET, COUNT, irq_flag = 0; state = IDLE; irq = 0.
  - rd = 0 for every addr.
  - Reset mid-count aborts immediately with no interrupt.
- Writes take effect at the rising edge where we=1. Reads have zero latency.
- Enable write at edge E0, with PRESET = N:
  - E0+1: LOAD.
  - E0+2: COUNT = N, CNT.
  - E0+2+max(N,1): COUNT = 0, INT, irq_flag = 1.
- MODE 1 period between irq pulses: max(N,1)+2 cycles.
- MODE 0: irq stays high (if IM) until software writes CTRL or PRESET.

## Configuration
- TIMER_AUTORELOAD_EN:
  - Defined: MODE 1 auto-reload is implemented as above.
  - Undefined: CTRL[2:1] is hardwired to 0 (reads 0, writes ignored), and every expiry follows MODE 0 behaviour.

## Test plan
- Assert reset low mid-count (COUNT=5) -> COUNT, CTRL, PRESET read 0 and irq=0 at once; after release, state IDLE with no interrupt.
- PRESET=3, write CTRL=0x9 (EN, IM, MODE 0) at edge E0 -> COUNT reads 3,2,1,0 at E0+2..E0+5. irq rises after E0+5 and holds; CTRL reads 0x8. Writing PRESET drops irq.
- With TIMER_AUTORELOAD_EN: PRESET=2, CTRL=0xB -> irq is a one-cycle pulse every 4 cycles; CTRL stays 0xB.
- PRESET=0, CTRL=0x9 -> INT reached at E0+3 (same as PRESET=1). Write COUNT=0x55 -> COUNT unchanged.
- CTRL=0x1 (IM=0) -> expiry still sets the internal flag but irq stays 0. Writing CTRL=0x8 without EN leaves irq 0, since the CTRL write clears the flag.
- Counting with COUNT=4, write CTRL=0x8 (EN=0) -> next edge IDLE, COUNT frozen at its value, no irq. Writing CTRL=0x9 again restarts from PRESET via LOAD.

Source files
------------

// File: rtl/timer_dev.sv
// -----------------------------------------------------------------------------
// timer_dev : memory-mapped countdown timer on the peripheral bus.
//
// Register map (word offset on addr):
//   0 CTRL   : bit0 EN, bits[2:1] MODE, bit3 IM, bits[31:4] read as 0
//   1 PRESET : 32-bit reload value
//   2 COUNT  : current count, read-only
//   3 -      : reads 0, writes ignored
//
// Ports:
//   clk   - system clock, all state updates on the rising edge
//   reset - asynchronous, active-low; clears every register and the FSM
//   addr  - word offset inside the device
//   we    - write strobe, already qualified by the bridge address decode
//   wd    - write data
//   rd    - read data, combinational from addr
//   irq   - interrupt request (IM & internal expiry flag)
//
// Build option:
//   TIMER_AUTORELOAD_EN - when defined, MODE 1 reloads PRESET after every
//   expiry and produces a one-cycle irq pulse. When undefined, CTRL[2:1] is
//   hardwired to 0 and every expiry is one-shot.
//
// Counting FSM: IDLE -> LOAD -> CNT -> INT. All decisions use register values
// from before the edge, so a bus write to EN is seen by the FSM one cycle
// after the write edge.
// -----------------------------------------------------------------------------
module timer_dev (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq
);

    localparam int DATA_W = 32;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    localparam logic [1:0] MODE_RELOAD = 2'd1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic              ctrl_en;
    logic              ctrl_im;
    logic [1:0]        ctrl_mode;
    logic [DATA_W-1:0] preset;
    logic [DATA_W-1:0] count;
    logic              irq_flag;

    logic wr_ctrl;
    logic wr_preset;
    logic auto_reload;

    // Strobes produced by the FSM and consumed by the register process.
    logic do_load;    // copy PRESET into COUNT
    logic do_dec;     // COUNT - 1
    logic do_expire;  // COUNT <= 0, raise irq_flag
    logic do_rearm;   // auto-reload: drop irq_flag to end the pulse
    logic do_stop;    // one-shot: clear EN

    assign wr_ctrl   = we && (addr == ADDR_CTRL);
    assign wr_preset = we && (addr == ADDR_PRESET);

    // -------------------------------------------------------------------------
    // MODE field: a real register only when auto-reload is built in.
    // -------------------------------------------------------------------------
`ifdef TIMER_AUTORELOAD_EN
    logic [1:0] mode_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q <= 2'b00;
        end else if (wr_ctrl) begin
            mode_q <= wd[2:1];
        end
    end

    assign ctrl_mode = mode_q;
`else
    logic unused_mode_bits;

    // Write data for the MODE field is deliberately dropped.
    assign unused_mode_bits = ^wd[2:1];
    assign ctrl_mode        = 2'b00;
`endif

    // MODE 2 and 3 behave like one-shot; only MODE 1 reloads.
    assign auto_reload = (ctrl_mode == MODE_RELOAD);

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state and control strobes
    // -------------------------------------------------------------------------
    always_comb begin
        next_state = state;
        do_load    = 1'b0;
        do_dec     = 1'b0;
        do_expire  = 1'b0;
        do_rearm   = 1'b0;
        do_stop    = 1'b0;

        case (state)
            S_IDLE: begin
                if (ctrl_en) begin
                    next_state = S_LOAD;
                end
            end

            S_LOAD: begin
                // Disabling during LOAD skips CNT and leaves COUNT untouched.
                if (!ctrl_en) begin
                    next_state = S_IDLE;
                end else begin
                    do_load    = 1'b1;
                    next_state = S_CNT;
                end
            end

            S_CNT: begin
                if (!ctrl_en) begin
                    next_state = S_IDLE;
                end else if (count > 32'd1) begin
                    do_dec = 1'b1;
                end else begin
                    // COUNT of 1 or 0 both expire, so PRESET=0 acts like 1
                    // and the counter can never wrap below zero.
                    do_expire  = 1'b1;
                    next_state = S_INT;
                end
            end

            S_INT: begin
                if (auto_reload) begin
                    do_rearm   = 1'b1;
                    next_state = ctrl_en ? S_LOAD : S_IDLE;
                end else begin
                    do_stop    = 1'b1;
                    next_state = S_IDLE;
                end
            end

            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // CTRL EN / IM
    // A bus write to CTRL takes priority over the one-shot EN clear, so
    // software rewriting CTRL on the expiry edge keeps what it wrote.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_en <= 1'b0;
            ctrl_im <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en <= wd[0];
                ctrl_im <= wd[3];
            end else if (do_stop) begin
                ctrl_en <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // PRESET
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            preset <= '0;
        end else if (wr_preset) begin
            preset <= wd;
        end
    end

    // -------------------------------------------------------------------------
    // COUNT: only the FSM changes it; bus writes to offset 2 are dropped.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (do_load) begin
            count <= preset;
        end else if (do_dec) begin
            count <= count - 32'd1;
        end else if (do_expire) begin
            count <= '0;
        end
    end

    // -------------------------------------------------------------------------
    // Expiry flag: setting wins over a same-edge clear from a bus write.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_flag <= 1'b0;
        end else if (do_expire) begin
            irq_flag <= 1'b1;
        end else if (wr_ctrl || wr_preset || do_rearm) begin
            irq_flag <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Read mux and interrupt output
    // -------------------------------------------------------------------------
    always_comb begin
        rd = '0;
        case (addr)
            ADDR_CTRL:   rd = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
            ADDR_PRESET: rd = preset;
            ADDR_COUNT:  rd = count;
            default:     rd = '0;
        endcase
    end

    assign irq = ctrl_im & irq_flag;

endmodule

// File: tb/tb_timer_dev.sv
module tb_timer_dev;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        irq;

    int total;
    int bad;

`ifdef TIMER_AUTORELOAD_EN
    localparam logic [31:0] MODE_MASK = 32'h0000_0006;
`else
    localparam logic [31:0] MODE_MASK = 32'h0000_0000;
`endif

    typedef struct packed {
        logic [1:0]  wa;
        logic        wen;
        logic [31:0] wdata;
        logic [1:0]  ra;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs [8];

    timer_dev dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wd    (wd),
        .rd    (rd),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic chk_rd(input string nm, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(nm, rd, exp);
    endtask

    task automatic chk_irq(input string nm, input logic exp);
        chk(nm, {31'd0, irq}, {31'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        addr = a;
        wd   = d;
        we   = 1'b1;
        tick();
        we   = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        we    = 1'b0;
        addr  = 2'd0;
        wd    = '0;

        //          wa     wen   wdata          ra     exp_rd                      exp_irq
        vecs[0] = '{2'd1, 1'b1, 32'hDEAD_BEEF, 2'd1, 32'hDEAD_BEEF,              1'b0};
        vecs[1] = '{2'd0, 1'b1, 32'hFFFF_FFF6, 2'd0, 32'h0000_0006 & MODE_MASK,  1'b0};
        vecs[2] = '{2'd2, 1'b1, 32'h0000_0055, 2'd2, 32'h0000_0000,              1'b0};
        vecs[3] = '{2'd3, 1'b1, 32'h1234_5678, 2'd3, 32'h0000_0000,              1'b0};
        vecs[4] = '{2'd1, 1'b0, 32'hFFFF_FFFF, 2'd1, 32'hDEAD_BEEF,              1'b0};
        vecs[5] = '{2'd1, 1'b1, 32'h0000_0000, 2'd1, 32'h0000_0000,              1'b0};
        vecs[6] = '{2'd0, 1'b1, 32'h0000_0008, 2'd0, 32'h0000_0008,              1'b0};
        vecs[7] = '{2'd0, 1'b1, 32'h0000_0000, 2'd0, 32'h0000_0000,              1'b0};

        // Reset state
        #3;
        for (int a = 0; a < 4; a++) begin
            chk_rd("reset_rd", 2'(a), 32'h0);
        end
        chk_irq("reset_irq", 1'b0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        tick();

        // Register access table
        for (int i = 0; i < 8; i++) begin
            addr = vecs[i].wa;
            wd   = vecs[i].wdata;
            we   = vecs[i].wen;
            tick();
            we   = 1'b0;
            chk_rd($sformatf("vec%0d_rd", i), vecs[i].ra, vecs[i].exp_rd);
            chk_irq($sformatf("vec%0d_irq", i), vecs[i].exp_irq);
        end

        // One-shot, PRESET=3
        bus_wr(2'd1, 32'd3);
        bus_wr(2'd0, 32'h9);            // edge E0
        tick();                         // E0+1, LOAD
        chk_rd("os_load_count", 2'd2, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();                     // E0+2+k
            chk_rd($sformatf("os_count_%0d", k), 2'd2, 32'(3 - k));
            chk_irq($sformatf("os_irq_%0d", k), (k == 3));
        end
        tick();                         // E0+6, EN cleared
        chk_rd("os_ctrl_after", 2'd0, 32'h8);
        chk_irq("os_irq_hold1", 1'b1);
        tick();
        tick();
        chk_irq("os_irq_hold2", 1'b1);
        bus_wr(2'd1, 32'd7);
        chk_irq("os_irq_clr_preset", 1'b0);

        // PRESET=0 behaves like PRESET=1; COUNT is read-only
        bus_wr(2'd1, 32'd0);
        bus_wr(2'd0, 32'h9);            // E0
        tick();
        tick();                         // E0+2
        chk_irq("p0_irq_e2", 1'b0);
        tick();                         // E0+3
        chk_irq("p0_irq_e3", 1'b1);
        bus_wr(2'd2, 32'h55);
        chk_rd("p0_count_ro", 2'd2, 32'd0);
        chk_irq("p0_count_wr_keeps_irq", 1'b1);
        bus_wr(2'd0, 32'h0);
        chk_irq("p0_irq_clr_ctrl", 1'b0);

        // IM=0: expiry does not drive irq
        bus_wr(2'd1, 32'd2);
        bus_wr(2'd0, 32'h1);            // E0
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk_irq($sformatf("im0_irq_%0d", k), 1'b0);
            if (k == 4) chk_rd("im0_count_zero", 2'd2, 32'd0);
        end
        chk_rd("im0_ctrl_en_clr", 2'd0, 32'h0);
        bus_wr(2'd0, 32'h8);
        chk_irq("im0_set_im", 1'b0);
        chk_rd("im0_ctrl", 2'd0, 32'h8);
        bus_wr(2'd0, 32'h0);

        // Disable mid-count, then restart via LOAD
        bus_wr(2'd1, 32'd10);
        bus_wr(2'd0, 32'h9);            // E0
        repeat (8) tick();              // E0+8
        chk_rd("dis_count4", 2'd2, 32'd4);
        bus_wr(2'd0, 32'h8);            // E0+9, FSM still sees EN=1
        chk_rd("dis_count_wr_edge", 2'd2, 32'd3);
        tick();
        chk_rd("dis_count_frozen1", 2'd2, 32'd3);
        tick();
        chk_rd("dis_count_frozen2", 2'd2, 32'd3);
        chk_irq("dis_irq", 1'b0);
        bus_wr(2'd0, 32'h9);            // E1
        tick();                         // E1+1, LOAD
        chk_rd("restart_load", 2'd2, 32'd3);
        tick();                         // E1+2
        chk_rd("restart_count", 2'd2, 32'd10);
        bus_wr(2'd0, 32'h0);            // E1+3
        tick();                         // E1+4
        chk_rd("restart_stop", 2'd2, 32'd9);

        // Disable while in LOAD: COUNT untouched, CNT skipped
        bus_wr(2'd1, 32'd20);
        bus_wr(2'd0, 32'h9);            // E2
        bus_wr(2'd0, 32'h8);            // E2+1, now in LOAD
        tick();                         // E2+2
        chk_rd("loadabort_count1", 2'd2, 32'd9);
        tick();
        chk_rd("loadabort_count2", 2'd2, 32'd9);
        chk_irq("loadabort_irq", 1'b0);
        bus_wr(2'd0, 32'h0);

        // Simultaneous events
        bus_wr(2'd1, 32'd1);
        bus_wr(2'd0, 32'h9);            // E0
        tick();
        tick();                         // E0+2, CNT with COUNT=1
        bus_wr(2'd1, 32'd1);            // E0+3: expiry and PRESET write
        chk_irq("sim_set_wins", 1'b1);
        bus_wr(2'd0, 32'h9);            // E0+4: CTRL write vs EN clear
        chk_rd("sim_ctrl_write_wins", 2'd0, 32'h9);
        chk_irq("sim_ctrl_clears", 1'b0);
        tick();
        tick();                         // E0+6
        chk_irq("sim_rerun_e6", 1'b0);
        tick();                         // E0+7
        chk_irq("sim_rerun_e7", 1'b1);
        bus_wr(2'd0, 32'h0);
        chk_irq("sim_clr", 1'b0);

        // MODE field behaviour
`ifdef TIMER_AUTORELOAD_EN
        bus_wr(2'd1, 32'd2);
        bus_wr(2'd0, 32'hB);            // E0
        chk_rd("ar_ctrl_wr", 2'd0, 32'hB);
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk_irq($sformatf("ar_irq_%0d", k), ((k % 4) == 0));
            if (k == 6) chk_rd("ar_reload_count", 2'd2, 32'd2);
        end
        chk_rd("ar_ctrl_kept", 2'd0, 32'hB);
        bus_wr(2'd0, 32'h0);
        chk_irq("ar_clr", 1'b0);
`else
        bus_wr(2'd1, 32'd2);
        bus_wr(2'd0, 32'hB);            // E0
        chk_rd("nm_ctrl_wr", 2'd0, 32'h9);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk_irq($sformatf("nm_irq_%0d", k), (k >= 4));
        end
        chk_rd("nm_ctrl_after", 2'd0, 32'h8);
        bus_wr(2'd0, 32'h0);
        chk_irq("nm_clr", 1'b0);
`endif

        // Asynchronous reset mid-count
        bus_wr(2'd1, 32'd10);
        bus_wr(2'd0, 32'h9);            // E0
        repeat (7) tick();              // E0+7
        chk_rd("rst_pre_count", 2'd2, 32'd5);
        reset = 1'b0;
        #1;
        chk_rd("rst_ctrl", 2'd0, 32'h0);
        chk_rd("rst_preset", 2'd1, 32'h0);
        chk_rd("rst_count", 2'd2, 32'h0);
        chk_irq("rst_irq", 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) tick();
        chk_rd("rst_after_count", 2'd2, 32'h0);
        chk_rd("rst_after_ctrl", 2'd0, 32'h0);
        chk_irq("rst_after_irq", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
